// File: rtl/demux_4_16_reg_pkg.sv
// Shared types and constants for the 1-to-4 registered word distributor.
// Optional feature macro: DEMUX_COUNT_EN (per-channel transfer counters).
package demux_4_16_reg_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_4_16_reg_slot.sv
// One-word EMPTY/FULL holding register for a single output channel.
// Loads are only issued when the slot is empty or draining this cycle.
module demux_slot
  import demux_4_16_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_r,
  output logic [WIDTH-1:0] o_y,
  output logic             o_v
);

  slot_state_t      r_state;
  slot_state_t      w_next;
  logic [WIDTH-1:0] r_y;

  // State and data register; data only changes on a load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_y     <= '0;
    end else begin
      r_state <= w_next;
      if (i_load) r_y <= i_d;
    end
  end

  // Next-state: refill keeps FULL, drain without refill empties
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_EMPTY: if (i_load) w_next = ST_FULL;
      ST_FULL:  if (i_r && !i_load) w_next = ST_EMPTY;
      default:  w_next = ST_EMPTY;
    endcase
  end

  assign o_y = r_y;
  assign o_v = (r_state == ST_FULL);

endmodule

// File: rtl/demux_4_16_reg.sv
// Registered 1-to-4 word distributor with per-channel valid/ready slots.
// Optional feature macro: DEMUX_COUNT_EN (adds cnt0..cnt3 saturating counters).
module demux_4_16_reg
  import demux_4_16_reg_pkg::*;
#(
`ifdef DEMUX_COUNT_EN
  parameter int CNT_W = CNT_W_DEF,
`endif
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s0,
  input  logic             s1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3,
`ifdef DEMUX_COUNT_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
`endif
  output logic             busy
);

  logic [1:0]       w_k;
  logic [3:0]       w_dec;
  logic [3:0]       w_load;
  logic [3:0]       w_v;
  logic [3:0]       w_r;
  logic             w_fire;
  logic [WIDTH-1:0] w_y [4];

  assign w_k    = {s0, s1};
  assign w_r    = {r3, r2, r1, r0};
  assign w_fire = in_valid & in_ready;

  // Channel decoder: one-hot of the selected channel
  always_comb begin
    w_dec = '0;
    unique case (w_k)
      CH0:     w_dec[0] = 1'b1;
      CH1:     w_dec[1] = 1'b1;
      CH2:     w_dec[2] = 1'b1;
      CH3:     w_dec[3] = 1'b1;
      default: w_dec = '0;
    endcase
  end

  assign w_load   = w_fire ? w_dec : 4'b0000;
  assign in_ready = !w_v[w_k] | w_r[w_k];

  for (genvar i = 0; i < 4; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load[i]),
      .i_d    (d),
      .i_r    (w_r[i]),
      .o_y    (w_y[i]),
      .o_v    (w_v[i])
    );
  end

  assign y0 = w_y[0];
  assign y1 = w_y[1];
  assign y2 = w_y[2];
  assign y3 = w_y[3];

  assign v0 = w_v[0];
  assign v1 = w_v[1];
  assign v2 = w_v[2];
  assign v3 = w_v[3];

  assign busy = |w_v;

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] r_cnt [4];

  // Saturating count of accepted words per channel
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        r_cnt[i] <= '0;
      end else if (w_load[i] && (r_cnt[i] != '1)) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];
`endif

endmodule

// File: tb/tb_demux_4_16_reg.sv
// Bench for demux_4_16_reg: directed vector table, then random traffic
// against a behavioural slot model; counter checks when DEMUX_COUNT_EN.
module tb_demux_4_16_reg;

  logic        clk;
  logic        rst;
  logic [15:0] d;
  logic        s0, s1;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y0, y1, y2, y3;
  logic        v0, v1, v2, v3;
  logic        r0, r1, r2, r3;
  logic        busy;
`ifdef DEMUX_COUNT_EN
  logic [7:0]  cnt0, cnt1, cnt2, cnt3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  demux_4_16_reg dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .s0       (s0),
    .s1       (s1),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .v0       (v0),
    .v1       (v1),
    .v2       (v2),
    .v3       (v3),
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
`ifdef DEMUX_COUNT_EN
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  s;
    logic [15:0] d;
    logic [3:0]  r;
    logic        rdy;
    logic [3:0]  v;
    int          ych;
    logic [15:0] y;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ysel(input int c);
    case (c)
      0:       return y0;
      1:       return y1;
      2:       return y2;
      default: return y3;
    endcase
  endfunction

  task automatic drive(input logic rs, input logic vl, input logic [1:0] s,
                       input logic [15:0] dd, input logic [3:0] r);
    rst      = rs;
    in_valid = vl;
    s0       = s[1];
    s1       = s[0];
    d        = dd;
    {r3, r2, r1, r0} = r;
  endtask

  logic        mv [4];
  logic [15:0] my [4];

  initial begin
    drive(1'b0, 1'b0, 2'd0, 16'h0, 4'h0);

    vecs[0]  = '{1, 1, 2'd0, 16'hFFFF, 4'h0, 1, 4'b0000, 0, 16'h0000};
    vecs[1]  = '{1, 1, 2'd1, 16'hFFFF, 4'h0, 1, 4'b0000, 1, 16'h0000};
    vecs[2]  = '{0, 0, 2'd0, 16'h0000, 4'h0, 1, 4'b0000, 3, 16'h0000};
    vecs[3]  = '{0, 1, 2'd0, 16'hA000, 4'hF, 1, 4'b0001, 0, 16'hA000};
    vecs[4]  = '{0, 1, 2'd1, 16'hA001, 4'hF, 1, 4'b0010, 1, 16'hA001};
    vecs[5]  = '{0, 1, 2'd2, 16'hA002, 4'hF, 1, 4'b0100, 2, 16'hA002};
    vecs[6]  = '{0, 1, 2'd3, 16'hA003, 4'hF, 1, 4'b1000, 3, 16'hA003};
    vecs[7]  = '{0, 0, 2'd0, 16'h0000, 4'hF, 1, 4'b0000, 0, 16'hA000};
    vecs[8]  = '{0, 1, 2'd2, 16'h1234, 4'hB, 1, 4'b0100, 2, 16'h1234};
    vecs[9]  = '{0, 1, 2'd2, 16'h5678, 4'hB, 0, 4'b0100, 2, 16'h1234};
    vecs[10] = '{0, 1, 2'd0, 16'hBEEF, 4'hB, 1, 4'b0101, 0, 16'hBEEF};
    vecs[11] = '{0, 1, 2'd2, 16'h5678, 4'hF, 1, 4'b0100, 2, 16'h5678};
    vecs[12] = '{0, 0, 2'd0, 16'h0000, 4'hF, 1, 4'b0000, 2, 16'h5678};
    vecs[13] = '{0, 1, 2'd1, 16'h1111, 4'h0, 1, 4'b0010, 1, 16'h1111};
    vecs[14] = '{0, 1, 2'd1, 16'h0F0F, 4'h2, 1, 4'b0010, 1, 16'h0F0F};
    vecs[15] = '{0, 0, 2'd1, 16'h0000, 4'h0, 0, 4'b0010, 1, 16'h0F0F};
    vecs[16] = '{1, 1, 2'd1, 16'h2222, 4'hF, 1, 4'b0000, 1, 16'h0000};
    vecs[17] = '{0, 0, 2'd0, 16'h0000, 4'h0, 1, 4'b0000, 0, 16'h0000};

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].vld, vecs[i].s, vecs[i].d, vecs[i].r);
      #1;
      if (!vecs[i].rst && i != 15)
        chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.v", i), 32'({v3, v2, v1, v0}), 32'(vecs[i].v));
      chk($sformatf("v%0d.y%0d", i, vecs[i].ych), 32'(ysel(vecs[i].ych)),
          32'(vecs[i].y));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(|vecs[i].v));
    end

`ifdef DEMUX_COUNT_EN
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 16'h0, 4'h0);
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, 2'd3, 16'(i), 4'hF);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 2'd0, 16'h0, 4'hF);
    @(negedge clk);
    chk("cnt3_sat", 32'(cnt3), 32'd255);
    chk("cnt012", 32'({cnt0, cnt1, cnt2}), 32'd0);
    drive(1'b1, 1'b0, 2'd0, 16'h0, 4'h0);
    @(negedge clk);
    chk("cnt_rst", 32'({cnt0, cnt1, cnt2, cnt3}), 32'd0);
`endif

    // random traffic; model follows the slot rules directly
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 16'h0, 4'h0);
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      mv[c] = 1'b0;
      my[c] = 16'h0;
    end
    begin
      logic        hold;
      logic        vl, rs, fire, m_rdy;
      logic [1:0]  s;
      logic [15:0] dd;
      logic [3:0]  r;
      hold = 1'b0;
      s    = 2'd0;
      dd   = 16'h0;
      for (int n = 0; n < 600; n++) begin
        @(negedge clk);
        rs = ($urandom_range(0, 59) == 0);
        if (!hold) begin
          vl = ($urandom_range(0, 3) != 0);
          s  = 2'($urandom_range(0, 3));
          dd = 16'($urandom);
        end
        r = 4'($urandom);
        drive(rs, vl, s, dd, r);
        #1;
        m_rdy = !mv[s] || r[s];
        chk("rnd.in_ready", 32'(in_ready), 32'(m_rdy));
        fire = vl && m_rdy;
        hold = vl && !m_rdy && !rs;
        @(posedge clk);
        if (rs) begin
          for (int c = 0; c < 4; c++) begin
            mv[c] = 1'b0;
            my[c] = 16'h0;
          end
          hold = 1'b0;
        end else begin
          for (int c = 0; c < 4; c++) begin
            if (mv[c] && r[c]) mv[c] = 1'b0;
            if (fire && s == 2'(c)) begin
              mv[c] = 1'b1;
              my[c] = dd;
            end
          end
        end
        #1;
        chk("rnd.v", 32'({v3, v2, v1, v0}),
            32'({mv[3], mv[2], mv[1], mv[0]}));
        chk("rnd.y", {y1, y0}, {my[1], my[0]});
        chk("rnd.y", {y3, y2}, {my[3], my[2]});
        chk("rnd.busy", 32'(busy), 32'(mv[0] | mv[1] | mv[2] | mv[3]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
